udp_rx_frame_buffer: RTL and testbench



---
 rtl/udp_rx_frame_buffer_if.sv | 42 ++++
 rtl/udp_rx_frame_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_udp_rx_frame_buffer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_frame_buffer_if.sv
// UDP receive frame buffer bus: MAC payload stream in, per-channel frame read port out.
// Latency: none (signal bundle only).
// Backpressure: none; the stream side has no ready, and the reader paces itself with rd_release.
// Ports: s_* payload stream (valid/sof/eof/err/dst_port/data); rd_* read select, data, length, release;
//        ch_ready per-channel frame available; drop_cnt dropped matched frames; busy write side active.
interface udp_rx_frame_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int CH_NUM = 4
);
    localparam int CH_W = $clog2(CH_NUM);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic              s_eof;
    logic              s_err;
    logic [15:0]       s_dst_port;

    logic [CH_NUM-1:0] ch_ready;
    logic [CH_W-1:0]   rd_ch;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   rd_len;
    logic              rd_release;
    logic [15:0]       drop_cnt;
    logic              busy;

    // master: MAC stream source plus frame consumer
    modport master (
        output s_valid, s_data, s_sof, s_eof, s_err, s_dst_port,
        output rd_ch, rd_addr, rd_release,
        input  ch_ready, rd_data, rd_len, drop_cnt, busy
    );

    // slave: the frame buffer itself
    modport slave (
        input  s_valid, s_data, s_sof, s_eof, s_err, s_dst_port,
        input  rd_ch, rd_addr, rd_release,
        output ch_ready, rd_data, rd_len, drop_cnt, busy
    );
endinterface

// File: rtl/udp_rx_frame_buffer.sv
// Demuxes UDP payload frames by destination port into per-channel ping-pong frame stores.
// Latency: commit visible on ch_ready one cycle after the eof edge; rd_data one cycle after rd_addr/rd_ch.
// Backpressure: none; every valid byte is consumed, frames that cannot be stored are dropped and counted.
// Ports: sys_clk, rst_n (async active-low); bus (slave modport) carries the payload stream,
//        the read/release port, ch_ready, drop_cnt and busy.
module udp_rx_frame_buffer #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 11,
    parameter int          CH_NUM    = 4,
    parameter logic [15:0] PORT_BASE = 16'd8080
) (
    input logic                  sys_clk,
    input logic                  rst_n,
    udp_rx_frame_buffer_if.slave bus
);
    localparam int CH_W   = $clog2(CH_NUM);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MEM_AW = CH_W + 1 + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                               state, state_nxt;
    logic [CH_W-1:0]                      cur_ch, cur_ch_nxt;
    logic [CNT_W-1:0]                     count, count_nxt;
    logic [15:0]                          drop_cnt;

    // per-channel two-bank bookkeeping
    logic [CH_NUM-1:0][1:0]               full;
    logic [CH_NUM-1:0]                    wr_bank;
    logic [CH_NUM-1:0]                    rd_bank;
    logic [CH_NUM-1:0][1:0][CNT_W-1:0]    len;

    logic [DATA_W-1:0]                    mem [2**MEM_AW];
    logic [DATA_W-1:0]                    rd_data;

    logic                                 wr_en;
    logic [MEM_AW-1:0]                    wr_addr;
    logic                                 commit;
    logic [CH_W-1:0]                      commit_ch;
    logic [CNT_W-1:0]                     commit_len;
    logic [1:0]                           drop_inc;
    logic [16:0]                          drop_sum;
    logic                                 rel_hit;
    logic [CH_NUM-1:0]                    ready;

    // port decode: anything below PORT_BASE wraps to a large offset and misses
    logic [15:0]                          port_off;
    logic                                 port_hit;
    logic [CH_W-1:0]                      port_ch;

    assign port_off = bus.s_dst_port - PORT_BASE;
    assign port_hit = (port_off < 16'(CH_NUM));
    assign port_ch  = port_off[CH_W-1:0];

    // ---------------------------------------------------------------
    // Write FSM: next state, RAM write and commit/drop decisions
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cur_ch_nxt = cur_ch;
        count_nxt  = count;
        wr_en      = 1'b0;
        wr_addr    = '0;
        commit     = 1'b0;
        commit_ch  = cur_ch;
        commit_len = '0;
        drop_inc   = 2'd0;

        if (bus.s_valid) begin
            if (bus.s_sof) begin
                // a new sof while still writing means the previous frame lost its eof
                if (state == ST_WRITE) begin
                    drop_inc = drop_inc + 2'd1;
                end
                if (!port_hit) begin
                    state_nxt = bus.s_eof ? ST_IDLE : ST_DISCARD;
                end else if (full[port_ch][wr_bank[port_ch]]) begin
                    drop_inc  = drop_inc + 2'd1;
                    state_nxt = bus.s_eof ? ST_IDLE : ST_DISCARD;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = {port_ch, wr_bank[port_ch], {ADDR_W{1'b0}}};
                    cur_ch_nxt = port_ch;
                    count_nxt  = CNT_W'(1);
                    if (bus.s_eof) begin
                        // single-byte frame
                        state_nxt = ST_IDLE;
                        if (bus.s_err) begin
                            drop_inc = drop_inc + 2'd1;
                        end else begin
                            commit     = 1'b1;
                            commit_ch  = port_ch;
                            commit_len = CNT_W'(1);
                        end
                    end else begin
                        state_nxt = ST_WRITE;
                    end
                end
            end else if (state == ST_WRITE) begin
                if (count == CNT_W'(DEPTH)) begin
                    // bank already holds DEPTH bytes: this byte does not fit
                    drop_inc  = drop_inc + 2'd1;
                    state_nxt = bus.s_eof ? ST_IDLE : ST_DISCARD;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = {cur_ch, wr_bank[cur_ch], count[ADDR_W-1:0]};
                    count_nxt = count + CNT_W'(1);
                    if (bus.s_eof) begin
                        state_nxt = ST_IDLE;
                        if (bus.s_err) begin
                            drop_inc = drop_inc + 2'd1;
                        end else begin
                            commit     = 1'b1;
                            commit_ch  = cur_ch;
                            commit_len = count + CNT_W'(1);
                        end
                    end
                end
            end else if (state == ST_DISCARD) begin
                if (bus.s_eof) begin
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cur_ch <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            cur_ch <= cur_ch_nxt;
            count  <= count_nxt;
        end
    end

    // saturating drop counter; up to two drops can land in one cycle (abort + full channel)
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // ---------------------------------------------------------------
    // Channel bank state: commit fills wr_bank, release frees rd_bank.
    // A commit and release on one channel in one cycle always hit different banks.
    // ---------------------------------------------------------------
    assign rel_hit = bus.rd_release & full[bus.rd_ch][rd_bank[bus.rd_ch]];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= '0;
            rd_bank <= '0;
            len     <= '0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (commit && commit_ch == CH_W'(k)) begin
                    full[k][wr_bank[k]] <= 1'b1;
                    len[k][wr_bank[k]]  <= commit_len;
                    wr_bank[k]          <= ~wr_bank[k];
                end
                if (rel_hit && bus.rd_ch == CH_W'(k)) begin
                    full[k][rd_bank[k]] <= 1'b0;
                    rd_bank[k]          <= ~rd_bank[k];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame store and read port
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.s_data;
        end
    end

    // uses the pre-release rd_bank, so a read issued with rd_release sees the old frame
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{bus.rd_ch, rd_bank[bus.rd_ch], bus.rd_addr}];
        end
    end

    always_comb begin
        ready = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            ready[k] = full[k][rd_bank[k]];
        end
    end

    assign bus.ch_ready = ready;
    assign bus.rd_len   = ready[bus.rd_ch] ? len[bus.rd_ch][rd_bank[bus.rd_ch]] : '0;
    assign bus.rd_data  = rd_data;
    assign bus.drop_cnt = drop_cnt;
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_udp_rx_frame_buffer.sv
// Self-checking bench for udp_rx_frame_buffer: randomized frames against a frame-level queue model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_udp_rx_frame_buffer;
    localparam int CH_NUM = 4;
    localparam int DEPTH  = 2048;
    localparam int PBASE  = 8080;

    typedef struct {
        int len;
        int base;
        int step;
    } frm_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    udp_rx_frame_buffer_if #(.DATA_W(8), .ADDR_W(11), .CH_NUM(CH_NUM)) bus ();

    udp_rx_frame_buffer #(
        .DATA_W(8), .ADDR_W(11), .CH_NUM(CH_NUM), .PORT_BASE(16'd8080)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // model: each channel is a queue of at most two committed frames, oldest first
    frm_t mq [CH_NUM][$];
    int   exp_drop;
    bit   exp_busy;
    bit   pending_abort;
    int   n_chk;
    int   n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input frm_t f, input int i);
        return 8'(f.base + i * f.step);
    endfunction

    task automatic idle_inputs();
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_sof      = 1'b0;
        bus.s_eof      = 1'b0;
        bus.s_err      = 1'b0;
        bus.s_dst_port = '0;
        bus.rd_release = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH_NUM; k++) mq[k].delete();
        exp_drop      = 0;
        exp_busy      = 1'b0;
        pending_abort = 1'b0;
    endtask

    // Sends one frame with random valid-low bubbles; optionally omits eof or pulses
    // rd_release (for the current rd_ch) on the eof beat. Updates the model afterwards.
    task automatic send_frame(input int port, input int len, input bit err, input bit no_eof,
                              input int base, input int step, input bit rel_on_eof);
        int   c;
        bit   hit, acc;
        frm_t f;
        c   = port - PBASE;
        hit = (port >= PBASE) && (port < PBASE + CH_NUM);
        if (pending_abort) begin
            exp_drop++;
            pending_abort = 1'b0;
        end
        acc = hit && (mq[c].size() < 2);
        if (hit && !acc) exp_drop++;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.s_valid    = 1'b0;
                bus.s_sof      = 1'($urandom);
                bus.s_eof      = 1'($urandom);
                bus.s_data     = 8'($urandom);
                bus.s_dst_port = 16'($urandom);
                tick();
            end
            bus.s_valid    = 1'b1;
            bus.s_data     = 8'(base + i * step);
            bus.s_sof      = (i == 0);
            bus.s_eof      = (i == len - 1) && !no_eof;
            bus.s_err      = bus.s_eof ? err : 1'($urandom);
            bus.s_dst_port = (i == 0) ? 16'(port) : 16'($urandom);
            bus.rd_release = rel_on_eof && bus.s_eof;
            tick();
        end
        idle_inputs();
        if (rel_on_eof && !no_eof && mq[int'(bus.rd_ch)].size() > 0)
            void'(mq[int'(bus.rd_ch)].pop_front());
        if (acc) begin
            if (no_eof) begin
                if (len <= DEPTH) pending_abort = 1'b1;
                else exp_drop++;
            end else if (len > DEPTH || err) begin
                exp_drop++;
            end else begin
                f.len = len; f.base = base; f.step = step;
                mq[c].push_back(f);
            end
        end
        exp_busy = no_eof;
    endtask

    task automatic check_state(input int c);
        logic [3:0] er;
        int         a;
        for (int k = 0; k < CH_NUM; k++) er[k] = (mq[k].size() > 0);
        check("ch_ready", 32'(bus.ch_ready), 32'(er));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        bus.rd_ch = 2'(c);
        #1;
        if (mq[c].size() > 0) begin
            check("rd_len", 32'(bus.rd_len), 32'(mq[c][0].len));
            for (int j = 0; j < 3; j++) begin
                a = (j == 0) ? 0 : (j == 1) ? mq[c][0].len - 1 : $urandom_range(0, mq[c][0].len - 1);
                bus.rd_addr = 11'(a);
                tick();
                check("rd_data", 32'(bus.rd_data), 32'(exp_byte(mq[c][0], a)));
            end
        end else begin
            check("rd_len_empty", 32'(bus.rd_len), 32'd0);
        end
    endtask

    // release with a simultaneous read of offset 0: data must come from the old frame
    task automatic release_ch(input int c);
        bus.rd_ch      = 2'(c);
        bus.rd_addr    = '0;
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        if (mq[c].size() > 0) begin
            check("rel_old_data", 32'(bus.rd_data), 32'(exp_byte(mq[c][0], 0)));
            void'(mq[c].pop_front());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.ch_ready), 32'd0);
        check({tag, "_len"},   32'(bus.rd_len),   32'd0);
        check({tag, "_data"},  32'(bus.rd_data),  32'd0);
        check({tag, "_drop"},  32'(bus.drop_cnt), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),     32'd0);
    endtask

    initial begin
        int port, r, c;
        n_chk = 0;
        n_pass = 0;
        idle_inputs();
        bus.rd_ch   = '0;
        bus.rd_addr = '0;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 64-byte frame to channel 1, incrementing bytes
        send_frame(8081, 64, 1'b0, 1'b0, 0, 1, 1'b0);
        check("tp1_ready", 32'(bus.ch_ready), 32'h2);
        bus.rd_ch = 2'd1; bus.rd_addr = 11'd5;
        tick();
        check("tp1_len", 32'(bus.rd_len), 32'd64);
        check("tp1_data5", 32'(bus.rd_data), 32'h05);
        check_state(1);
        release_ch(1);

        // three frames to channel 0 without release: third is dropped
        send_frame(8080, 16, 1'b0, 1'b0, 8'h10, 1, 1'b0);
        send_frame(8080, 16, 1'b0, 1'b0, 8'h40, 3, 1'b0);
        send_frame(8080, 16, 1'b0, 1'b0, 8'h80, 5, 1'b0);
        check("tp2_drop", 32'(bus.drop_cnt), 32'd1);
        check_state(0);
        release_ch(0);
        check_state(0);

        // overflow by one byte, then an exactly bank-sized frame
        send_frame(8082, DEPTH + 1, 1'b0, 1'b0, 7, 1, 1'b0);
        check_state(2);
        send_frame(8082, DEPTH, 1'b0, 1'b0, 3, 7, 1'b0);
        check("tp3_len", 32'(bus.rd_len), 32'(DEPTH));
        check_state(2);

        // errored frame on ch3, then an unmatched port
        send_frame(8083, 20, 1'b1, 1'b0, 1, 1, 1'b0);
        check_state(3);
        send_frame(9000, 30, 1'b0, 1'b0, 1, 1, 1'b0);
        check_state(3);

        // missing eof on ch0 followed by a 1-byte frame
        release_ch(0);
        send_frame(8080, 10, 1'b0, 1'b1, 2, 2, 1'b0);
        check_state(1);
        send_frame(8080, 1, 1'b0, 1'b0, 8'hA5, 0, 1'b0);
        check_state(0);

        // release coinciding with a commit on ch0
        release_ch(0);
        send_frame(8080, 10, 1'b0, 1'b0, 9, 1, 1'b0);
        bus.rd_ch = 2'd0;
        send_frame(8080, 20, 1'b0, 1'b0, 50, 1, 1'b1);
        check("tp6_ready0", 32'(bus.ch_ready[0]), 32'd1);
        check("tp6_len", 32'(bus.rd_len), 32'd20);
        check_state(0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) port = PBASE + $urandom_range(0, CH_NUM - 1);
            else if (r == 8) port = ($urandom_range(0, 1) == 0) ? PBASE - 1 : PBASE + CH_NUM;
            else port = 9000;
            bus.rd_ch = 2'($urandom);
            send_frame(port, $urandom_range(1, 40), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 9) == 0), $urandom_range(0, 255),
                       $urandom_range(1, 9), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 2) == 0) release_ch($urandom_range(0, CH_NUM - 1));
            c = $urandom_range(0, CH_NUM - 1);
            check_state(c);
        end

        // reset in the middle of a frame, then bare bytes without sof are ignored
        send_frame(8081, 20, 1'b0, 1'b1, 4, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 8'(i); bus.s_eof = (i == 4);
            bus.s_dst_port = 16'd8081;
            tick();
        end
        idle_inputs();
        check_state(1);
        send_frame(8081, 12, 1'b0, 1'b0, 33, 1, 1'b0);
        check_state(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
